// File: rtl/note_serializer.sv
// Note link transmitter: frames the active-note vector LSB-first, one bit per slot.
// Optional trailing even-parity slot when NOTE_SER_PARITY_EN is defined.
module note_serializer #(
    parameter int NUM_NOTES  = 48,
    parameter int BIT_PERIOD = 128
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [NUM_NOTES-1:0] notes,
    input  logic                 notes_valid,
    output logic                 note_serial_sync,
    output logic                 note_serial_data,
    output logic                 frame_start,
    output logic                 idle
);

`ifdef NOTE_SER_PARITY_EN
    localparam int FRAME_LEN = NUM_NOTES + 1;
`else
    localparam int FRAME_LEN = NUM_NOTES;
`endif

    localparam int SW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
    localparam int IW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    localparam logic [SW-1:0] SLOT_LAST = SW'(BIT_PERIOD - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(FRAME_LEN - 1);

    logic [SW-1:0]        slot_cnt;
    logic [IW-1:0]        bit_idx;
    logic [NUM_NOTES-1:0] pending;
    logic [FRAME_LEN-1:0] frame;

    logic [NUM_NOTES-1:0] load_src;
    logic [FRAME_LEN-1:0] load_val;
    logic                 slot_end;
    logic                 frame_end;

    // A strobe on the boundary cycle bypasses the pending register.
    always_comb begin
        load_src = notes_valid ? notes : pending;
`ifdef NOTE_SER_PARITY_EN
        load_val = {^load_src, load_src};
`else
        load_val = load_src;
`endif
    end

    assign slot_end  = (slot_cnt == SLOT_LAST);
    assign frame_end = slot_end && (bit_idx == IDX_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt         <= SLOT_LAST;
            bit_idx          <= IDX_LAST;
            pending          <= '0;
            frame            <= '0;
            note_serial_sync <= 1'b0;
            note_serial_data <= 1'b0;
            frame_start      <= 1'b0;
            idle             <= 1'b1;
        end else begin
            frame_start <= 1'b0;

            if (notes_valid) begin
                pending <= notes;
            end

            if (frame_end) begin
                if (en) begin
                    slot_cnt         <= '0;
                    bit_idx          <= '0;
                    frame            <= load_val;
                    note_serial_data <= load_val[0];
                    note_serial_sync <= 1'b1;
                    frame_start      <= 1'b1;
                    idle             <= 1'b0;
                end else begin
                    // Park at the boundary; re-checked every cycle.
                    note_serial_sync <= 1'b0;
                    note_serial_data <= 1'b0;
                    idle             <= 1'b1;
                end
            end else if (slot_end) begin
                slot_cnt         <= '0;
                bit_idx          <= bit_idx + 1'b1;
                frame            <= frame >> 1;
                note_serial_data <= frame[1];
                note_serial_sync <= 1'b0;
            end else begin
                slot_cnt <= slot_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_note_serializer.sv
// Directed bench for note_serializer with BIT_PERIOD=4, NUM_NOTES=48.
// Expectations follow NOTE_SER_PARITY_EN when it is defined.
module tb_note_serializer;

`ifdef NOTE_SER_PARITY_EN
    localparam int FL = 49;
`else
    localparam int FL = 48;
`endif
    localparam int BP = 4;
    localparam int P  = FL * BP;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [47:0] notes;
    logic        notes_valid;
    logic        note_serial_sync;
    logic        note_serial_data;
    logic        frame_start;
    logic        idle;

    int checks;
    int errors;
    int cyc;

    note_serializer #(
        .NUM_NOTES (48),
        .BIT_PERIOD(BP)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en              (en),
        .notes           (notes),
        .notes_valid     (notes_valid),
        .note_serial_sync(note_serial_sync),
        .note_serial_data(note_serial_data),
        .frame_start     (frame_start),
        .idle            (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s @cyc %0d: observed %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    int f2, f3, f4, f5, fr;

    initial begin
        checks = 0;
        errors = 0;
        cyc = 0;
        rst_n = 1'b0;
        en = 1'b1;
        notes = '0;
        notes_valid = 1'b0;
        f2 = 1 + P;
        f3 = 1 + 2 * P;
        f4 = 1 + 3 * P;
        f5 = f4 + P + 7;

        // Reset state
        #12;
        chk("rst_sync", note_serial_sync, 1'b0);
        chk("rst_data", note_serial_data, 1'b0);
        chk("rst_fs", frame_start, 1'b0);
        chk("rst_idle", idle, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // Frame 1: pending=0, first boundary on first edge
        tick();
        chk("f1_fs", frame_start, 1'b1);
        chk("f1_sync", note_serial_sync, 1'b1);
        chk("f1_idle", idle, 1'b0);
        tick();
        chk("f1_fs_pulse", frame_start, 1'b0);
        run_to(4);
        chk("f1_sync_c4", note_serial_sync, 1'b1);
        tick();
        chk("f1_sync_c5", note_serial_sync, 1'b0);
        while (cyc < f2 - 1) begin
            chk("f1_data0", note_serial_data, 1'b0);
            chk("f1_fs0", frame_start, 1'b0);
            if (cyc == 100) begin
                notes = 48'h0000_0000_0005;
                notes_valid = 1'b1;
            end else begin
                notes_valid = 1'b0;
            end
            tick();
        end
        notes_valid = 1'b0;
        chk("f1_data_last", note_serial_data, 1'b0);

        // Frame 2: 5 -> 1,0,1,0
        tick();
        chk("f2_fs", frame_start, 1'b1);
        chk("f2_sync", note_serial_sync, 1'b1);
        chk("f2_b0a", note_serial_data, 1'b1);
        run_to(f2 + 3);
        chk("f2_b0d", note_serial_data, 1'b1);
        tick();
        chk("f2_b1a", note_serial_data, 1'b0);
        chk("f2_b1_sync", note_serial_sync, 1'b0);
        run_to(f2 + 7);
        chk("f2_b1d", note_serial_data, 1'b0);
        tick();
        chk("f2_b2a", note_serial_data, 1'b1);
        run_to(f2 + 11);
        chk("f2_b2d", note_serial_data, 1'b1);
        tick();
        chk("f2_b3", note_serial_data, 1'b0);

        // Frame 3: bypass strobe on boundary cycle
        run_to(f3 - 1);
        chk("f2_end_fs", frame_start, 1'b0);
        notes = 48'h8000_0000_0001;
        notes_valid = 1'b1;
        tick();
        chk("f3_fs", frame_start, 1'b1);
        chk("f3_b0", note_serial_data, 1'b1);
        notes = 48'h0000_0000_0002;
        tick();
        notes_valid = 1'b0;
        notes = '0;
        run_to(f3 + 4);
        chk("f3_b1", note_serial_data, 1'b0);
        run_to(f3 + 47 * BP);
        chk("f3_b47a", note_serial_data, 1'b1);
        run_to(f3 + 47 * BP + 3);
        chk("f3_b47d", note_serial_data, 1'b1);

        // Frame 4: later strobe value 2; en dropped in slot 20
        run_to(f4);
        chk("f4_fs", frame_start, 1'b1);
        chk("f4_b0", note_serial_data, 1'b0);
        run_to(f4 + 4);
        chk("f4_b1", note_serial_data, 1'b1);
        run_to(f4 + 20 * BP + 1);
        en = 1'b0;
        run_to(f4 + 30 * BP);
        chk("f4_run_idle", idle, 1'b0);
        run_to(f4 + 47 * BP);
        chk("f4_b47_idle", idle, 1'b0);
        chk("f4_b47", note_serial_data, 1'b0);
`ifdef NOTE_SER_PARITY_EN
        run_to(f4 + 48 * BP);
        chk("f4_parity", note_serial_data, 1'b1);
        chk("f4_par_idle", idle, 1'b0);
`endif
        run_to(f4 + P);
        chk("stop_idle", idle, 1'b1);
        chk("stop_sync", note_serial_sync, 1'b0);
        chk("stop_data", note_serial_data, 1'b0);
        chk("stop_fs", frame_start, 1'b0);
        notes = 48'h0000_0000_0003;
        notes_valid = 1'b1;
        tick();
        notes_valid = 1'b0;
        run_to(f5 - 1);
        chk("hold_idle", idle, 1'b1);
        chk("hold_fs", frame_start, 1'b0);
        en = 1'b1;

        // Frame 5: restart the cycle after en returns
        tick();
        chk("f5_fs", frame_start, 1'b1);
        chk("f5_sync", note_serial_sync, 1'b1);
        chk("f5_idle", idle, 1'b0);
        chk("f5_b0", note_serial_data, 1'b1);
        run_to(f5 + 4);
        chk("f5_b1", note_serial_data, 1'b1);
        run_to(f5 + 8);
        chk("f5_b2", note_serial_data, 1'b0);

        // Asynchronous reset in slot 30
        run_to(f5 + 30 * BP + 1);
        chk("pre_rst_idle", idle, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("arst_sync", note_serial_sync, 1'b0);
        chk("arst_data", note_serial_data, 1'b0);
        chk("arst_idle", idle, 1'b1);
        #2;
        rst_n = 1'b1;
        tick();
        fr = cyc;
        chk("rs_fs", frame_start, 1'b1);
        chk("rs_sync", note_serial_sync, 1'b1);
        chk("rs_data", note_serial_data, 1'b0);
        run_to(fr + 3);
        chk("rs_sync_end", note_serial_sync, 1'b1);
        tick();
        chk("rs_sync_off", note_serial_sync, 1'b0);
        run_to(fr + P);
        chk("rs_next_fs", frame_start, 1'b1);
        chk("rs_next_data", note_serial_data, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/note_serializer.md
# note_serializer

Transmitter for the two-wire note link (`note_serial_sync`, `note_serial_data`) that carries the 48-lane active-note vector from the game logic to the display/deserializer side. It snapshots a note vector once per frame and emits it LSB-first, one bit per fixed-length slot. Sync is high for the whole bit-0 slot. Outputs are fully registered so they can cross to the receiving logic, which samples once per slot.

## Interface
Parameters
- `NUM_NOTES`, default 48: payload bits per frame; receiver index range 0..NUM_NOTES-1.
- `BIT_PERIOD`, default 128: clocks per bit slot. Must be ≥2 and match the receiver's sample divider.

Ports
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  transmit enable; sampled only at frame boundaries.
- `notes`  in  NUM_NOTES  note vector; bit i = lane i active.
- `notes_valid`  in  1  one-cycle strobe: capture `notes` into the pending register.
- `note_serial_sync`  out  1  high for the entire slot carrying bit 0.
- `note_serial_data`  out  1  current payload bit, stable for the whole slot.
- `frame_start`  out  1  one-cycle pulse in the first cycle of each bit-0 slot.
- `idle`  out  1  high while stopped at a frame boundary with `en` low.

## Operation
- Frame length `FRAME_LEN` = NUM_NOTES, or NUM_NOTES+1 with parity (see Configuration).
- State:
  - `slot_cnt` counts 0..BIT_PERIOD-1 and wraps.
  - `bit_idx` counts 0..FRAME_LEN-1.
  - `pending` (NUM_NOTES) and `frame` (FRAME_LEN) shift register.
- Reset values:
  - Outputs: `note_serial_sync`=0, `note_serial_data`=0, `frame_start`=0, `idle`=1.
  - Counters: `slot_cnt`=BIT_PERIOD-1, `bit_idx`=FRAME_LEN-1.
  - Registers: `pending`=0, `frame`=0.
- Pending capture: `pending` <= `notes` on any cycle `notes_valid`=1. The last strobe before a frame load wins.
- Slot advance: when `slot_cnt`=BIT_PERIOD-1 and not idle, `slot_cnt`<=0. Otherwise `slot_cnt` increments.
- At a slot boundary with `bit_idx`<FRAME_LEN-1:
  - `bit_idx`++.
  - `frame` shifts right.
  - `note_serial_data`<=next bit.
  - `note_serial_sync`<=0.
- Frame boundary: a slot boundary with `bit_idx`=FRAME_LEN-1.
  - If `en`=1:
    - Load `frame` from `notes` if `notes_valid`=1 in that cycle (bypass), else from `pending`.
    - `bit_idx`<=0; `note_serial_data`<=bit 0 of the loaded value.
    - `note_serial_sync`<=1; `frame_start`<=1 for one cycle; `idle`<=0.
  - If `en`=0:
    - Counters hold at the boundary values.
    - Outputs sync=0, data=0; `idle`<=1.
    - Re-evaluated every cycle; the frame starts the cycle after `en` returns high.
- `en` deasserted mid-frame has no effect until the frame boundary: frames are never truncated.
- Reset asserted mid-frame: immediate return to reset values. The partial frame is discarded.

## Timing
- First `clk` edge after `rst_n` release with `en`=1 is a frame boundary. Sync and bit 0 appear one cycle after reset release.
- Each bit is held exactly BIT_PERIOD cycles; sync is high BIT_PERIOD cycles per frame.
- Frame period is FRAME_LEN×BIT_PERIOD cycles when continuously enabled; there are no gap slots.
- Capture latency: a `notes_valid` strobe at cycle t is transmitted in the frame whose boundary is ≥t. At most one frame period plus one cycle.
- `frame_start` coincides with the first sync-high cycle.

## Configuration
- `NOTE_SER_PARITY_EN` defined:
  - FRAME_LEN = NUM_NOTES+1.
  - Final slot carries the even parity (XOR) of the NUM_NOTES payload bits, computed at frame load.
- Not defined: FRAME_LEN = NUM_NOTES, no parity slot; logic identical otherwise.

## Test plan
All scenarios use BIT_PERIOD=4, NUM_NOTES=48, macro undefined unless stated.
- Reset release, `en`=1, `pending`=0 -> `frame_start` at cycle 1; sync high cycles 1–4; data 0 for 192 cycles; next `frame_start` at cycle 193.
- `notes_valid` with 48'h0000_0000_0005 before first boundary -> data 1,0,1 in slots 0–2, then 0. Each bit held 4 cycles.
- `notes_valid` on the exact frame-boundary cycle with 48'h8000_0000_0001 -> that frame carries bit0=1 and bit47=1 (bypass). A strobe one cycle later appears only in the following frame.
- `en` dropped in slot 20 -> frame completes through slot 47; `idle`=1, outputs 0. Re-raise `en` -> `frame_start` the next cycle.
- `rst_n` pulsed low in slot 30 -> outputs 0 immediately (asynchronous). Restart with a fresh frame after release.
- `NOTE_SER_PARITY_EN`, notes=48'h7 -> 49 slots; slot 48 data=1; frame period 196 cycles.
